// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS datapath: memory-unit FSM states and
// memory operation kinds.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mem_op_e;

  // Resolve simultaneous strobes: a store wins over a fetch, a fetch over a load.
  function automatic mem_op_e pick_op(input logic memwrite, input logic irwrite);
    if (memwrite)     return WRITE;
    else if (irwrite) return FETCH;
    else              return READ;
  endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Memory-side handshake bundle between mem_unit (master) and the memory
// system (slave).
interface mem_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_unit_flopenr.sv
// Enable register with synchronous active-high reset; holds the instruction
// and memory data registers of mem_unit.
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_unit.sv
// Memory access unit: turns decoder strobes into one bus transaction and
// stalls the decoder until it completes. MEM_UNIT_ALIGN_CHECK_EN enables misalignment trapping.
module mem_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IorD,
  input  logic              IRwrite,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              misalign
);

  mem_state_e        state_d, state_q;
  mem_op_e           op_d, op_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  logic              req;
  logic              misal;
  logic              busy;
  logic              instr_en;
  logic              data_en;
  logic [ADDR_W-1:0] sel_addr;

  assign req      = IRwrite | memread | memwrite;
  assign sel_addr = IorD ? aluout : pc;
  assign busy     = (state_q == BUSY);

`ifdef MEM_UNIT_ALIGN_CHECK_EN
  assign misal = (sel_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    instr_en = 1'b0;
    data_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = sel_addr;
          op_d    = pick_op(memwrite, IRwrite);
          wdata_d = writedata;
          // A misaligned access never reaches the bus; DONE carries the error pulse.
          state_d = misal ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus_ready) begin
          state_d  = DONE;
          instr_en = (op_q == FETCH);
          data_en  = (op_q == READ);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_UNIT_ALIGN_CHECK_EN
  logic misalign_d, misalign_q;

  always_comb begin
    misalign_d = (state_q == IDLE) && req && misal;
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // Bus outputs are forced to zero everywhere except BUSY.
  assign bus_req   = busy;
  assign bus_we    = busy && (op_q == WRITE);
  assign bus_addr  = busy ? addr_q  : '0;
  assign bus_wdata = busy ? wdata_q : '0;

  assign stall = !reset && (((state_q == IDLE) && req) || busy);

  flopenr #(.WIDTH(DATA_W)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (instr_en),
    .d     (bus_rdata),
    .q     (instr)
  );

  flopenr #(.WIDTH(DATA_W)) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .en    (data_en),
    .d     (bus_rdata),
    .q     (data)
  );

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed and random transactions compared
// against a transaction-level reference model.
module tb_mem_unit;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_UNIT_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          IorD, IRwrite, memwrite, memread;
  logic [AW-1:0] pc, aluout;
  logic [DW-1:0] writedata;
  logic [DW-1:0] instr, data;
  logic          stall, misalign;

  mem_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .IorD      (IorD),
    .IRwrite   (IRwrite),
    .memwrite  (memwrite),
    .memread   (memread),
    .pc        (pc),
    .aluout    (aluout),
    .writedata (writedata),
    .instr     (instr),
    .data      (data),
    .stall     (stall),
    .bus_req   (bus.bus_req),
    .bus_we    (bus.bus_we),
    .bus_addr  (bus.bus_addr),
    .bus_wdata (bus.bus_wdata),
    .bus_ready (bus.bus_ready),
    .bus_rdata (bus.bus_rdata),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] exp_instr, exp_data;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drop_strobes();
    memwrite = 1'b0;
    IRwrite  = 1'b0;
    memread  = 1'b0;
  endtask

  // One complete request. The decoder holds strobes while stalled; ready is
  // raised in BUSY cycle number nwait. With hold=1 strobes stay up through DONE.
  task automatic txn(input logic mw, input logic irw, input logic mr, input logic iord,
                     input logic [31:0] p, input logic [31:0] alu,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int unsigned nwait, input bit hold);
    logic [31:0] ea;
    logic [1:0]  lo;
    bit          is_w, is_f, mis;
    int unsigned stalls, busy_cyc;
    ea   = iord ? alu : p;
    lo   = ea[1:0];
    is_w = mw;
    is_f = !mw && irw;
    mis  = ALIGN_EN && (lo != 2'b00);
    IorD = iord; pc = p; aluout = alu; writedata = wd;
    memwrite = mw; IRwrite = irw; memread = mr;
    bus.bus_ready = 1'b0;
    #1;
    stalls   = 0;
    busy_cyc = 0;
    while (stall === 1'b1 && stalls < 64) begin
      stalls++;
      if (bus.bus_req === 1'b1) begin
        busy_cyc++;
        chk1("bus_we", bus.bus_we, is_w);
        chk32("bus_addr", bus.bus_addr, ea);
        if (is_w) chk32("bus_wdata", bus.bus_wdata, wd);
        chk32("instr_stable", instr, exp_instr);
        chk32("data_stable", data, exp_data);
      end
      bus.bus_ready = (busy_cyc != 0) && (busy_cyc == nwait);
      bus.bus_rdata = bus.bus_ready ? rd : $urandom;
      step();
    end
    bus.bus_ready = 1'b0;
    chk32("stall_cycles", stalls, mis ? 32'd1 : nwait + 1);
    chk32("busy_cycles", busy_cyc, mis ? 32'd0 : nwait);
    chk1("misalign_done", misalign, mis);
    chk1("bus_req_done", bus.bus_req, 1'b0);
    if (!mis) begin
      if (is_f)       exp_instr = rd;
      else if (!is_w) exp_data  = rd;
    end
    chk32("instr", instr, exp_instr);
    chk32("data", data, exp_data);
    if (!hold) begin
      drop_strobes();
      step();
      chk1("misalign_pulse_end", misalign, 1'b0);
      chk1("idle_stall", stall, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [2:0]  r;
    logic [31:0] a;

    reset = 1'b1;
    drop_strobes();
    IorD = 1'b0; pc = '0; aluout = '0; writedata = '0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = '0;
    exp_instr = '0;
    exp_data  = '0;
    step();
    IRwrite = 1'b1;
    #1;
    chk1("stall_in_reset", stall, 1'b0);
    step();
    IRwrite = 1'b0;
    reset = 1'b0;
    #1;
    chk32("reset_instr", instr, '0);
    chk32("reset_data", data, '0);
    chk1("reset_misalign", misalign, 1'b0);
    chk1("reset_bus_req", bus.bus_req, 1'b0);
    chk32("reset_bus_addr", bus.bus_addr, '0);
    chk1("reset_stall", stall, 1'b0);
    bus.bus_ready = 1'b1;
    step();
    chk1("idle_ignores_ready", bus.bus_req, 1'b0);
    chk1("idle_ignores_ready_stall", stall, 1'b0);
    bus.bus_ready = 1'b0;

    // fetch from pc with three BUSY cycles
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h8C02_0004, 3, 1'b0);
    // store, ready in the first BUSY cycle
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_AAAA, 1, 1'b0);
    // load to give data a known non-zero value
    txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 2, 1'b0);
    // store and fetch together: store wins
    txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0108, 32'h0BAD_F00D, 32'h7777_7777, 2, 1'b0);
    // load from a misaligned data address
    txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 32'h1111_2222, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r = 3'($urandom_range(1, 7));
      a = $urandom;
      if (($urandom % 2) == 0) a[1:0] = 2'b00;
      txn(r[0], r[1], r[2], 1'($urandom % 2), a, a ^ 32'h0000_1000, $urandom, $urandom,
          $urandom_range(1, 4), 1'b0);
    end

    // back-to-back: strobes held through DONE must not be accepted there
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, 32'hA5A5_0001, 1, 1'b1);
    n = 0;
    while (bus.bus_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk32("b2b_gap", n, 32'd2);
    bus.bus_rdata = 32'hA5A5_0002;
    bus.bus_ready = 1'b1;
    step();
    bus.bus_ready = 1'b0;
    exp_instr = 32'hA5A5_0002;
    chk1("b2b_done_stall", stall, 1'b0);
    chk32("b2b_instr", instr, exp_instr);
    drop_strobes();
    step();

    // reset while BUSY, then a late ready must be discarded
    memread = 1'b1; IorD = 1'b1; aluout = 32'h0000_0200;
    #1;
    step();
    chk1("pre_reset_busy", bus.bus_req, 1'b1);
    reset = 1'b1;
    #1;
    chk1("busy_reset_stall", stall, 1'b0);
    step();
    reset = 1'b0;
    drop_strobes();
    bus.bus_ready = 1'b1;
    bus.bus_rdata = 32'h1234_5678;
    exp_instr = '0;
    exp_data  = '0;
    #1;
    chk1("post_reset_bus_req", bus.bus_req, 1'b0);
    chk1("post_reset_stall", stall, 1'b0);
    step();
    step();
    chk1("late_ready_bus_req", bus.bus_req, 1'b0);
    chk32("late_ready_instr", instr, exp_instr);
    chk32("late_ready_data", data, exp_data);
    bus.bus_ready = 1'b0;

    // recovery after reset
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 32'h2402_0001, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
